multicycle_cpu: RTL and testbench
=================================

# multicycle_cpu

Parametrised multicycle processor core, the successor to the fixed 48-bit/24-bit core. Width, address space, register count and reset vector are parameters. Adds a request/ready memory handshake with arbitrary wait states, a defined opcode set, and halt/illegal-instruction status. Sits at the top of the processor and connects to a single unified instruction/data memory.

## Interface
- DATA_W, 48: register, ALU and memory word width (≥ 24)
- ADDR_W, 12: word address width; also the immediate width
- REG_AW, 2: register address width (2^REG_AW registers)
- RESET_PC, 'h800: PC value after reset
- Instruction width IW = 6 + 3·REG_AW + ADDR_W (24 at defaults); IW ≤ DATA_W
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_adr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data; valid in the cycle where mem_ready is high
- mem_ready  in  1  transfer completes on the edge where mem_req && mem_ready
- halted  out  1  core stopped by HALT or an illegal opcode
- illegal  out  1  stopped on an undefined opcode
- pc_dbg  out  ADDR_W  current PC

## Operation
- Instruction is the IW least-significant bits of the fetched word. From the MSB down, the fields are: op[6], Rd, Rs1, Rs2, imm[ADDR_W].
- Opcodes:
  - 0x00 ADD: Rd = Rs1 + Rs2
  - 0x01 SUB: Rd = Rs1 − Rs2
  - 0x02 AND: Rd = Rs1 & Rs2
  - 0x03 OR: Rd = Rs1 | Rs2
  - 0x04 ADDI: Rd = Rs1 + zext(imm)
  - 0x08 LD: Rd = mem[ea]
  - 0x09 ST: mem[ea] = Rs2
  - 0x10 BEQ: if Rs1 == Rs2, PC = imm
  - 0x11 JMP: PC = imm
  - 0x3F HALT
- Effective address: ea = (imm + Rs1[ADDR_W-1:0]) mod 2^ADDR_W.
- Arithmetic is modulo 2^DATA_W; no flags are kept.
- All registers are writable, including register 0.
- Any other opcode sets halted = 1 and illegal = 1. Rd, memory and PC are unchanged.
- State machine:
  - FETCH: mem_req = 1, mem_we = 0, mem_adr = PC; hold until ready, then latch IR and go to DECODE.
  - DECODE: read Rs1 and Rs2 into A and B; PC = PC + 1, wrapping mod 2^ADDR_W.
  - EXEC, ALU ops: compute into ALUOut, go to WB.
  - EXEC, LD/ST: compute ea, go to MEM.
  - EXEC, BEQ/JMP: update PC, go to FETCH.
  - EXEC, HALT/illegal: go to HALT.
  - MEM: mem_req = 1 with mem_we = (op == ST), mem_adr = ea, mem_wdata = B; hold until ready. LD latches MDR and goes to WB; ST goes to FETCH.
  - WB: write ALUOut or MDR to Rd, go to FETCH.
  - HALT: terminal; only reset leaves it. mem_req = 0.
- Handshake:
  - mem_adr, mem_we and mem_wdata stay stable while mem_req is high and ready is low.
  - mem_req drops in the cycle after completion; exactly one transfer per request.
  - mem_ready while mem_req = 0 is ignored.

## Timing
- Reset values:
  - state = FETCH, PC = RESET_PC, all registers = 0
  - mem_req = 0, mem_we = 0, mem_adr = 0, mem_wdata = 0
  - halted = 0, illegal = 0
- mem_req rises in the first cycle after reset deasserts.
- Cycles per instruction with zero wait states:
  - ALU ops: 4
  - LD: 5
  - ST: 4
  - BEQ/JMP: 3
  - HALT: 3, then halted = 1
- Each wait-state cycle adds one cycle.
- Reset asserted mid-transfer, including while mem_req is high and waiting: the core returns to reset values on the next edge. The pending transfer is abandoned, and a late mem_ready is ignored.
- The register write from WB is visible to the next instruction's DECODE.

## Structure
- Shared package `cpu_pkg`: opcode constants, state enum, field-extraction functions parametrised by REG_AW/ADDR_W.
- Sub-modules:
  - `cpu_regfile` (2R1W, synchronous write, combinational read, synchronous reset to 0)
  - the existing ALU, widened by DATA_W
- FSM and datapath registers (IR, A, B, ALUOut, MDR, PC) live in `multicycle_cpu`.

## Test plan
- Zero-wait memory, defaults, program at 0x800 = ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT -> r3 = 12; halted = 1 after 4+4+4+3 cycles; pc_dbg = 0x804.
- Memory with 3 wait states on every access; ST r3 to 0x010, then LD r0 from 0x010 -> mem[0x010] = 12, r0 = 12. During each wait, mem_adr and mem_wdata are stable and mem_req stays high.
- BEQ r1,r1,0x900 -> next fetch address is 0x900. BEQ with r1 ≠ r2 -> fetch continues at PC+1.
- PC = 0xFFF with ADDI -> next fetch address is 0x000.
- Opcode 0x20 -> halted = 1, illegal = 1, no register or memory write, mem_req stays low.
- Reset pulsed while a fetch waits on mem_ready = 0 -> next cycle PC = 0x800, mem_req = 0. mem_ready = 1 arriving during reset has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states, ALU controls
// and instruction field positions as functions of the register/address widths.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_LD   = 6'h08;
  localparam logic [5:0] OP_ST   = 6'h09;
  localparam logic [5:0] OP_BEQ  = 6'h10;
  localparam logic [5:0] OP_JMP  = 6'h11;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_t;

  // Layout from the MSB down: op[6], rd, rs1, rs2, imm[addr_w].
  function automatic int instr_w(int reg_aw, int addr_w);
    return 6 + 3 * reg_aw + addr_w;
  endfunction

  function automatic int op_lsb(int reg_aw, int addr_w);
    return 3 * reg_aw + addr_w;
  endfunction

  function automatic int rd_lsb(int reg_aw, int addr_w);
    return 2 * reg_aw + addr_w;
  endfunction

  function automatic int rs1_lsb(int reg_aw, int addr_w);
    return reg_aw + addr_w;
  endfunction

  function automatic int rs2_lsb(int addr_w);
    return addr_w;
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                      OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_HALT};
  endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// Unified instruction/data memory port: request/ready handshake with wait states.
interface cpu_mem_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, adr, wdata, input rdata, ready);
  modport slave  (input req, we, adr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: add, subtract, and, or, all modulo 2^DATA_W.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    // NOTE: y gets a value before the case so no path leaves it unassigned (no latch).
    y = a + b;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/cpu_regfile.sv
// 2-read/1-write register file: combinational reads, synchronous write and reset.
module cpu_regfile #(
  parameter int DATA_W = 48,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  // NOTE: state is updated with <= so every register samples pre-edge values.
  // NOTE: resetting this array is fine because it is a handful of flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer around IR, A, B, ALUOut,
// MDR and PC, talking to one unified memory through a request/ready port.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 48,
  parameter int                ADDR_W   = 12,
  parameter int                REG_AW   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h800
) (
  input  logic              clk,
  input  logic              reset,
  cpu_mem_if.master         mem,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int IW      = instr_w(REG_AW, ADDR_W);
  localparam int OP_LSB  = op_lsb(REG_AW, ADDR_W);
  localparam int RD_LSB  = rd_lsb(REG_AW, ADDR_W);
  localparam int RS1_LSB = rs1_lsb(REG_AW, ADDR_W);
  localparam int RS2_LSB = rs2_lsb(ADDR_W);

  state_t            state, state_nx;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] a_q, b_q, alu_out, mdr;
  logic [ADDR_W-1:0] pc;
  logic              illegal_q;

  logic [5:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [ADDR_W-1:0] imm;

  assign op  = ir[OP_LSB +: 6];
  assign rd  = ir[RD_LSB +: REG_AW];
  assign rs1 = ir[RS1_LSB +: REG_AW];
  assign rs2 = ir[RS2_LSB +: REG_AW];
  assign imm = ir[ADDR_W-1:0];

  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd, alu_b, alu_y;
  logic              rf_we;
  alu_op_t           alu_op;

  assign rf_we = (state == S_WB);
  assign rf_wd = (op == OP_LD) ? mdr : alu_out;

  cpu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk  (clk),
    .reset(reset),
    .we   (rf_we),
    .wa   (rd),
    .wd   (rf_wd),
    .ra1  (rs1),
    .rd1  (rf_rd1),
    .ra2  (rs2),
    .rd2  (rf_rd2)
  );

  // ADDI and the effective-address computation both use the zero-extended immediate.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_q;
    unique case (op)
      OP_SUB:                alu_op = ALU_SUB;
      OP_AND:                alu_op = ALU_AND;
      OP_OR:                 alu_op = ALU_OR;
      OP_ADDI, OP_LD, OP_ST: alu_b  = DATA_W'(imm);
      default: ;
    endcase
  end

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a (a_q),
    .b (alu_b),
    .op(alu_op),
    .y (alu_y)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (mem.ready) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_nx = S_WB;
          OP_LD, OP_ST:                           state_nx = S_MEM;
          OP_BEQ, OP_JMP:                         state_nx = S_FETCH;
          default:                                state_nx = S_HALT;
        endcase
      end
      S_MEM:    if (mem.ready) state_nx = (op == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Reset gates the request so a transfer pending at reset is dropped immediately.
  always_comb begin
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.adr   = '0;
    mem.wdata = '0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          mem.req = 1'b1;
          mem.adr = pc;
        end
        S_MEM: begin
          mem.req   = 1'b1;
          mem.we    = (op == OP_ST);
          mem.adr   = alu_out[ADDR_W-1:0];
          mem.wdata = b_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_FETCH: if (mem.ready) ir <= mem.rdata[IW-1:0];
        S_DECODE: begin
          a_q <= rf_rd1;
          b_q <= rf_rd2;
          pc  <= pc + ADDR_W'(1);
        end
        S_EXEC: begin
          alu_out <= alu_y;
          if (op == OP_JMP || (op == OP_BEQ && a_q == b_q)) pc <= imm;
          if (!is_legal(op)) illegal_q <= 1'b1;
        end
        S_MEM: if (mem.ready && op == OP_LD) mdr <= mem.rdata;
        default: ;
      endcase
    end
  end

  assign halted  = (state == S_HALT);
  assign illegal = illegal_q;
  assign pc_dbg  = pc;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench: memory model with configurable wait states and a scoreboard
// of expected bus transactions, plus cycle-count and status checks per program.
module tb_multicycle_cpu;
  import cpu_pkg::*;

  localparam int DATA_W = 48;
  localparam int ADDR_W = 12;
  localparam int REG_AW = 2;

  logic              clk;
  logic              reset;
  logic              halted;
  logic              illegal;
  logic [ADDR_W-1:0] pc_dbg;

  cpu_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  multicycle_cpu #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_AW  (REG_AW),
    .RESET_PC(12'h800)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (mem_bus),
    .halted (halted),
    .illegal(illegal),
    .pc_dbg (pc_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  txn_t              exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                wait_n   = 0;
  bit                manual   = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Upper junk bits confirm that only the low instruction-width bits are decoded.
  function automatic logic [DATA_W-1:0] enc(logic [5:0] op, logic [1:0] rd, logic [1:0] rs1,
                                            logic [1:0] rs2, logic [11:0] imm);
    return {24'hC3C3C3, op, rd, rs1, rs2, imm};
  endfunction

  task automatic exp_rd(input logic [ADDR_W-1:0] a);
    txn_t t;
    t.we = 1'b0; t.adr = a; t.wdata = '0;
    exp_q.push_back(t);
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    txn_t t;
    t.we = 1'b1; t.adr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Memory model and scoreboard monitor; evaluates 1 ns after each falling edge.
  initial begin
    int   cnt;
    txn_t cur, e;
    cnt           = 0;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (manual || reset) begin
        cnt = 0;
        if (!manual) mem_bus.ready = 1'b0;
        continue;
      end
      if (mem_bus.ready) cnt = 0;
      mem_bus.ready = 1'b0;
      if (mem_bus.req) begin
        if (cnt == 0) cur = '{mem_bus.we, mem_bus.adr, mem_bus.wdata};
        else check("bus_stable", 64'({mem_bus.we, mem_bus.adr, mem_bus.wdata}),
                   64'({cur.we, cur.adr, cur.wdata}));
        if (cnt == wait_n) begin
          mem_bus.ready = 1'b1;
          mem_bus.rdata = mem[mem_bus.adr];
          if (mem_bus.we) mem[mem_bus.adr] = mem_bus.wdata;
          check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_we", 64'(mem_bus.we), 64'(e.we));
            check("sb_adr", 64'(mem_bus.adr), 64'(e.adr));
            if (e.we) check("sb_wdata", 64'(mem_bus.wdata), 64'(e.wdata));
          end
        end else begin
          cnt++;
        end
      end else if (cnt != 0) begin
        check("req_hold", 64'(mem_bus.req), 64'(1));
        cnt = 0;
      end
    end
  end

  task automatic start_test(input int w);
    @(negedge clk);
    reset  = 1'b1;
    manual = 1'b0;
    wait_n = w;
    exp_q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog(input string name, input int exp_cycles,
                          input logic [ADDR_W-1:0] exp_pc, input logic exp_ill);
    int cycles;
    cycles = 0;
    @(negedge clk);
    reset = 1'b0;
    while (!halted && cycles < 500) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({name, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    check({name, "_halted"}, 64'(halted), 64'(1));
    check({name, "_illegal"}, 64'(illegal), 64'(exp_ill));
    check({name, "_pc"}, 64'(pc_dbg), 64'(exp_pc));
    check({name, "_sb_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(mem_bus.req), 64'(0));
    check("rst_we", 64'(mem_bus.we), 64'(0));
    check("rst_adr", 64'(mem_bus.adr), 64'(0));
    check("rst_wdata", 64'(mem_bus.wdata), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    check("rst_pc", 64'(pc_dbg), 64'(12'h800));

    // Arithmetic program, zero wait states.
    start_test(0);
    mem[12'h800] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 12'd5);
    mem[12'h801] = enc(OP_ADDI, 2'd2, 2'd0, 2'd0, 12'd7);
    mem[12'h802] = enc(OP_ADD,  2'd3, 2'd1, 2'd2, 12'd0);
    mem[12'h803] = enc(OP_HALT, 2'd0, 2'd0, 2'd0, 12'd0);
    for (int a = 'h800; a <= 'h803; a++) exp_rd(12'(a));
    run_prog("t1", 15, 12'h804, 1'b0);
    check("t1_r3", 64'(dut.u_rf.regs[3]), 64'(12));

    // Store/load with three wait states on every access.
    start_test(3);
    mem[12'h800] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 12'd5);
    mem[12'h801] = enc(OP_ADDI, 2'd2, 2'd0, 2'd0, 12'd7);
    mem[12'h802] = enc(OP_ADD,  2'd3, 2'd1, 2'd2, 12'd0);
    mem[12'h803] = enc(OP_ST,   2'd0, 2'd0, 2'd3, 12'h010);
    mem[12'h804] = enc(OP_LD,   2'd0, 2'd0, 2'd0, 12'h010);
    mem[12'h805] = enc(OP_ST,   2'd0, 2'd1, 2'd0, 12'h00C);
    mem[12'h806] = enc(OP_HALT, 2'd0, 2'd0, 2'd0, 12'd0);
    exp_rd(12'h800); exp_rd(12'h801); exp_rd(12'h802); exp_rd(12'h803);
    exp_wr(12'h010, 48'd12);
    exp_rd(12'h804); exp_rd(12'h010);
    exp_rd(12'h805);
    exp_wr(12'h011, 48'd12);
    exp_rd(12'h806);
    run_prog("t2", 58, 12'h807, 1'b0);
    check("t2_mem010", 64'(mem[12'h010]), 64'(12));
    check("t2_mem011", 64'(mem[12'h011]), 64'(12));

    // Taken and not-taken branches.
    start_test(0);
    mem[12'h800] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 12'd3);
    mem[12'h801] = enc(OP_BEQ,  2'd0, 2'd1, 2'd1, 12'h900);
    mem[12'h900] = enc(OP_ADDI, 2'd2, 2'd0, 2'd0, 12'd9);
    mem[12'h901] = enc(OP_BEQ,  2'd0, 2'd1, 2'd2, 12'h950);
    mem[12'h902] = enc(OP_HALT, 2'd0, 2'd0, 2'd0, 12'd0);
    exp_rd(12'h800); exp_rd(12'h801); exp_rd(12'h900); exp_rd(12'h901); exp_rd(12'h902);
    run_prog("t3", 17, 12'h903, 1'b0);

    // PC wraps from 0xFFF to 0x000.
    start_test(0);
    mem[12'h800] = enc(OP_JMP,  2'd0, 2'd0, 2'd0, 12'hFFF);
    mem[12'hFFF] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 12'd1);
    mem[12'h000] = enc(OP_HALT, 2'd0, 2'd0, 2'd0, 12'd0);
    exp_rd(12'h800); exp_rd(12'hFFF); exp_rd(12'h000);
    run_prog("t4", 10, 12'h001, 1'b0);

    // Undefined opcode stops the core without side effects.
    start_test(0);
    mem[12'h800] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 12'd4);
    mem[12'h801] = enc(6'h20,   2'd1, 2'd1, 2'd1, 12'h010);
    exp_rd(12'h800); exp_rd(12'h801);
    run_prog("t5", 7, 12'h802, 1'b1);
    check("t5_r1", 64'(dut.u_rf.regs[1]), 64'(4));
    check("t5_mem010", 64'(mem[12'h010]), 64'(0));
    rq = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (mem_bus.req) rq++;
    end
    check("t5_req_low", 64'(rq), 64'(0));
    check("t5_still_halted", 64'(halted), 64'(1));

    // Reset while a fetch is waiting; late ready during reset is ignored.
    @(negedge clk);
    reset         = 1'b1;
    manual        = 1'b1;
    mem_bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_fetch0_req", 64'(mem_bus.req), 64'(1));
    check("t6_fetch0_adr", 64'(mem_bus.adr), 64'(12'h800));
    mem_bus.ready = 1'b1;
    mem_bus.rdata = enc(OP_JMP, 2'd0, 2'd0, 2'd0, 12'h123);
    @(negedge clk);
    mem_bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t6_jmp_adr", 64'(mem_bus.adr), 64'(12'h123));
    check("t6_jmp_pc", 64'(pc_dbg), 64'(12'h123));
    repeat (2) @(negedge clk);
    #1;
    check("t6_wait_req", 64'(mem_bus.req), 64'(1));
    check("t6_wait_adr", 64'(mem_bus.adr), 64'(12'h123));
    @(negedge clk);
    reset         = 1'b1;
    mem_bus.ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_pc", 64'(pc_dbg), 64'(12'h800));
    check("t6_rst_req", 64'(mem_bus.req), 64'(0));
    check("t6_rst_adr", 64'(mem_bus.adr), 64'(0));
    check("t6_rst_we", 64'(mem_bus.we), 64'(0));
    check("t6_rst_wdata", 64'(mem_bus.wdata), 64'(0));
    @(posedge clk);
    #1;
    check("t6_rst_pc2", 64'(pc_dbg), 64'(12'h800));
    @(negedge clk);
    reset         = 1'b0;
    mem_bus.ready = 1'b0;
    #1;
    check("t6_restart_req", 64'(mem_bus.req), 64'(1));
    check("t6_restart_adr", 64'(mem_bus.adr), 64'(12'h800));
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_late_pc", 64'(pc_dbg), 64'(12'h800));
    check("t6_no_late_req", 64'(mem_bus.req), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
